// File: rtl/conv_encode_if.sv
// Bit-in / symbol-out handshake bundle for the rate-1/2 convolutional encoder.
// The master modport is the side that drives the bits; slave is the encoder.
interface conv_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  data_out;
    logic        frame_done;
    logic [15:0] sym_cnt;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, data_out, frame_done, sym_cnt
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, data_out, frame_done, sym_cnt
    );
endinterface

// File: rtl/conv_encode.sv
// Rate-1/2, K=3 convolutional encoder with a registered symbol output and
// an automatic two-symbol zero tail that returns the trellis to state 00.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | between frames; next accepted bit starts a new frame
// ST_DATA  | inside a frame, accepting information bits
// ST_TAIL1 | last bit taken; loading first zero tail symbol
// ST_TAIL2 | loading second zero tail symbol; frame_done on load
module conv_encode #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic         clk,
    input  logic         rst_n,
    conv_encode_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL1, ST_TAIL2} state_e;

    state_e      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        out_valid_q, out_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [1:0]  data_q, data_d;
    logic [15:0] sym_cnt_q, sym_cnt_d;

    logic        slot_free;
    logic        in_ready;
    logic        accept;
    logic        tail_load;
    logic        load;
    logic        u;
    logic [2:0]  taps;

    always_comb begin
        slot_free    = !out_valid_q || bus.out_ready;
        // Held low during reset even though the output slot looks free.
        in_ready     = rst_n && slot_free && (state_q == ST_IDLE || state_q == ST_DATA);
        accept       = bus.in_valid && in_ready;
        tail_load    = slot_free && (state_q == ST_TAIL1 || state_q == ST_TAIL2);
        load         = accept || tail_load;
        u            = accept && bus.in_bit;
        taps         = {u, s1_q, s2_q};

        state_d      = state_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        out_valid_d  = out_valid_q;
        data_d       = data_q;
        sym_cnt_d    = sym_cnt_q;
        frame_done_d = 1'b0;

        if (load) begin
            data_d      = {^(taps & G0), ^(taps & G1)};
            out_valid_d = 1'b1;
            s1_d        = u;
            s2_d        = s1_q;
            sym_cnt_d   = (state_q == ST_IDLE) ? 16'd1 : sym_cnt_q + 16'd1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            data_d      = 2'b00;
        end

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    state_d = bus.in_last ? ST_TAIL1 : ST_DATA;
                end
            end
            ST_TAIL1: begin
                if (tail_load) begin
                    state_d = ST_TAIL2;
                end
            end
            ST_TAIL2: begin
                if (tail_load) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= 2'b00;
            sym_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            data_q       <= data_d;
            sym_cnt_q    <= sym_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = out_valid_q ? data_q : 2'b00;
    assign bus.frame_done = frame_done_q;
    assign bus.sym_cnt    = sym_cnt_q;
endmodule

// File: tb/tb_conv_encode.sv
// Directed bench for conv_encode: hand-computed symbol streams for plain,
// single-bit, stalled, back-to-back, reset-interrupted and all-zero frames.
module tb_conv_encode;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_encode_if bus ();

    conv_encode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // {out_valid, data_out, frame_done, sym_cnt}
    function automatic logic [19:0] obs_now();
        return {bus.out_valid, bus.data_out, bus.frame_done, bus.sym_cnt};
    endfunction

    task automatic test_reset();
        logic [19:0] obs;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = obs_now();
        n_cmp++;
        if (obs !== 20'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got %h want %h", obs, 20'h0);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset in_ready: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    // Sends an n-bit frame with out_ready high; syms holds symbol i at [2i+1:2i].
    task automatic test_frame(input string name, input int n,
                              input logic [15:0] bits, input logic [31:0] syms);
        logic [19:0] obs, exp;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                bus.in_valid = 1'b1;
                bus.in_bit   = bits[i];
                bus.in_last  = (i == n - 1);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_bit   = 1'b0;
                bus.in_last  = 1'b0;
            end
            #1;
            n_cmp++;
            if (bus.in_ready !== (i < n)) begin
                n_bad++;
                $display("FAIL %s[%0d] in_ready: got %b want %b", name, i, bus.in_ready, (i < n));
            end
            @(posedge clk);
            #1;
            obs = obs_now();
            exp = {1'b1, syms[2*i +: 2], (i == n + 1), 16'(i + 1)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s[%0d] v/sym/done/cnt: got %h want %h", name, i, obs, exp);
            end
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle in_ready: got %b want 1", name, bus.in_ready);
        end
        @(posedge clk);
        #1;
        obs = obs_now();
        exp = {1'b0, 2'b00, 1'b0, 16'(n + 2)};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s drain: got %h want %h", name, obs, exp);
        end
    endtask

    task automatic test_backpressure();
        logic       v_t [9]   = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic       b_t [9]   = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
        logic       l_t [9]   = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic       or_t [9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        logic       rdy_t [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
        logic [1:0] sym_t [9] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        int         cnt_t [9] = '{1, 2, 2, 2, 2, 3, 4, 5, 6};
        logic [19:0] obs, exp;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid  = v_t[i];
            bus.in_bit    = b_t[i];
            bus.in_last   = l_t[i];
            bus.out_ready = or_t[i];
            #1;
            n_cmp++;
            if (bus.in_ready !== rdy_t[i]) begin
                n_bad++;
                $display("FAIL stall[%0d] in_ready: got %b want %b", i, bus.in_ready, rdy_t[i]);
            end
            @(posedge clk);
            #1;
            obs = obs_now();
            exp = {1'b1, sym_t[i], (i == 8), 16'(cnt_t[i])};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL stall[%0d] v/sym/done/cnt: got %h want %h", i, obs, exp);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        obs = obs_now();
        n_cmp++;
        if (obs !== {1'b0, 2'b00, 1'b0, 16'd6}) begin
            n_bad++;
            $display("FAIL stall drain: got %h want %h", obs, {1'b0, 2'b00, 1'b0, 16'd6});
        end
    endtask

    task automatic test_back_to_back();
        logic       b_t [8]   = '{1, 1, 0, 0, 0, 1, 0, 0};
        logic       l_t [8]   = '{0, 1, 0, 0, 0, 1, 0, 0};
        logic       v_t [8]   = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic       rdy_t [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        logic [1:0] sym_t [8] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11};
        logic [19:0] obs, exp;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = v_t[i];
            bus.in_bit   = b_t[i];
            bus.in_last  = l_t[i];
            #1;
            n_cmp++;
            if (bus.in_ready !== rdy_t[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d] in_ready: got %b want %b", i, bus.in_ready, rdy_t[i]);
            end
            @(posedge clk);
            #1;
            obs = obs_now();
            exp = {1'b1, sym_t[i], (i == 3 || i == 7), 16'((i % 4) + 1)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b[%0d] v/sym/done/cnt: got %h want %h", i, obs, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_tail();
        logic [19:0] obs;
        logic [19:0] exp_t [3] = '{{1'b1, 2'b11, 1'b0, 16'd1},
                                   {1'b1, 2'b10, 1'b0, 16'd2},
                                   {1'b1, 2'b11, 1'b1, 16'd3}};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        bus.in_last   = 1'b0;
        @(posedge clk);
        #1;
        bus.in_last = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #1;
        obs = obs_now();
        n_cmp++;
        if (obs !== {1'b1, 2'b01, 1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL midrst tail1: got %h want %h", obs, {1'b1, 2'b01, 1'b0, 16'd3});
        end
        rst_n = 1'b0;
        #1;
        obs = obs_now();
        n_cmp++;
        if (obs !== 20'h0) begin
            n_bad++;
            $display("FAIL midrst outputs: got %h want %h", obs, 20'h0);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst in_ready: got %b want 0", bus.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        bus.in_last  = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst release in_ready: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_bit   = 1'b0;
            bus.in_last  = 1'b0;
            obs = obs_now();
            n_cmp++;
            if (obs !== exp_t[i]) begin
                n_bad++;
                $display("FAIL midrst new[%0d]: got %h want %h", i, obs, exp_t[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_frame("basic", 4, 16'b1101, 32'b11_01_01_00_10_11);
        test_frame("single", 1, 16'b1, 32'b11_10_11);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tail();
        test_frame("zeros", 8, 16'b0, 32'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
